// File: rtl/mmcm_seq_pkg.sv
// Shared types for the MMCM lock sequencer.
// State encoding and retry counter width.
package mmcm_seq_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        S_HOLD_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_PWRDN,
        S_FAULT
    } state_e;

endpackage

// File: rtl/mmcm_seq_if.sv
// Control/status bundle between a clock-manager controller and the sequencer.
// master drives the MMCM status and requests, slave returns controls.
interface mmcm_seq_if;
    import mmcm_seq_pkg::*;

    logic               mmcm_locked;
    logic               pwrdwn_req;
    logic               fault_clr;
    logic               mmcm_rst;
    logic               mmcm_pwrdwn;
    logic               ready;
    logic               fault;
    logic               lol_pulse;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        output mmcm_locked, pwrdwn_req, fault_clr,
        input  mmcm_rst, mmcm_pwrdwn, ready, fault, lol_pulse, retry_cnt
    );

    modport slave (
        input  mmcm_locked, pwrdwn_req, fault_clr,
        output mmcm_rst, mmcm_pwrdwn, ready, fault, lol_pulse, retry_cnt
    );

endinterface

// File: rtl/mmcm_seq_sync.sv
// Two-flop synchronizer for the asynchronous MMCM LOCKED status.
// Both stages clear to 0 on reset.
module mmcm_seq_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/mmcm_lock_sequencer.sv
// MMCM reset/lock sequencer: hold reset, wait for lock, qualify, run.
// Define MMCM_SEQ_AUTO_RELOCK_EN to relock automatically after loss of lock.
module mmcm_lock_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int MAX_RETRIES         = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MMCM_LOCKED,
    input  logic               PWRDWN_REQ,
    input  logic               FAULT_CLR,
    output logic               MMCM_RST,
    output logic               MMCM_PWRDWN,
    output logic               READY,
    output logic               FAULT,
    output logic               LOL_PULSE,
    output logic [RETRY_W-1:0] RETRY_CNT
);

    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int STB_W  = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_MAX   = STB_W'(LOCK_STABLE_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic locked_s;

    mmcm_seq_sync u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (MMCM_LOCKED),
        .q_o   (locked_s)
    );

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [STB_W-1:0]   stb_q, stb_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               mrst_q, mrst_d;
    logic               pwdn_q, pwdn_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               lol_q, lol_d;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lol_d   = 1'b0;
        if (PWRDWN_REQ) begin
            state_d = S_PWRDN;
        end else begin
            unique case (state_q)
                S_HOLD_RST: begin
                    if (hold_q >= HOLD_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // a lock seen on the timeout cycle still wins
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (tmo_q >= TMO_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = S_HOLD_RST;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (stb_q >= STB_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        lol_d = 1'b1;
`ifdef MMCM_SEQ_AUTO_RELOCK_EN
                        state_d = S_HOLD_RST;
                        retry_d = '0;
`else
                        state_d = S_FAULT;
`endif
                    end
                end
                S_PWRDN: begin
                    state_d = S_HOLD_RST;
                    retry_d = '0;
                end
                S_FAULT: begin
                    if (FAULT_CLR) begin
                        state_d = S_HOLD_RST;
                        retry_d = '0;
                    end
                end
                default: state_d = S_HOLD_RST;
            endcase
        end
    end

    // every state entry restarts its counter from zero
    always_comb begin
        hold_d = hold_q;
        tmo_d  = tmo_q;
        stb_d  = stb_q;
        if (state_d != state_q) begin
            hold_d = '0;
            tmo_d  = '0;
            stb_d  = '0;
        end else begin
            if (state_q == S_HOLD_RST && hold_q != HOLD_MAX)
                hold_d = hold_q + HOLD_W'(1);
            if (state_q == S_WAIT_LOCK && tmo_q != TMO_MAX)
                tmo_d = tmo_q + TMO_W'(1);
            if (state_q == S_STABLE && stb_q != STB_MAX)
                stb_d = stb_q + STB_W'(1);
        end
    end

    always_comb begin
        mrst_d  = state_d inside {S_HOLD_RST, S_PWRDN, S_FAULT};
        pwdn_d  = state_d == S_PWRDN;
        ready_d = state_d == S_RUN;
        fault_d = state_d == S_FAULT;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_HOLD_RST;
            hold_q  <= '0;
            tmo_q   <= '0;
            stb_q   <= '0;
            retry_q <= '0;
            mrst_q  <= 1'b1;
            pwdn_q  <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            lol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            stb_q   <= stb_d;
            retry_q <= retry_d;
            mrst_q  <= mrst_d;
            pwdn_q  <= pwdn_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            lol_q   <= lol_d;
        end
    end

    assign MMCM_RST    = mrst_q;
    assign MMCM_PWRDWN = pwdn_q;
    assign READY       = ready_q;
    assign FAULT       = fault_q;
    assign LOL_PULSE   = lol_q;
    assign RETRY_CNT   = retry_q;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Bench for mmcm_lock_sequencer: vector table, corner sequences, random run.
// Honours MMCM_SEQ_AUTO_RELOCK_EN for the loss-of-lock expectations.
module tb_mmcm_lock_sequencer;

    localparam int RH = 4;
    localparam int TO = 100;
    localparam int LS = 8;
    localparam int MR = 2;
    localparam int NTR = 330;

`ifdef MMCM_SEQ_AUTO_RELOCK_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    localparam int P_HOLD = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_OFF  = 4;
    localparam int P_FLT  = 5;

    logic clk = 1'b0;
    logic rst;

    mmcm_seq_if bus ();

    always #5 clk = ~clk;

    mmcm_lock_sequencer #(
        .RST_HOLD_CYCLES     (RH),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (LS),
        .MAX_RETRIES         (MR)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .MMCM_LOCKED (bus.mmcm_locked),
        .PWRDWN_REQ  (bus.pwrdwn_req),
        .FAULT_CLR   (bus.fault_clr),
        .MMCM_RST    (bus.mmcm_rst),
        .MMCM_PWRDWN (bus.mmcm_pwrdwn),
        .READY       (bus.ready),
        .FAULT       (bus.fault),
        .LOL_PULSE   (bus.lol_pulse),
        .RETRY_CNT   (bus.retry_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: phase, cycles spent in it, and a 2-deep lock delay line
    int       m_ph;
    int       m_age;
    int       m_retry;
    bit [1:0] m_sync;
    bit       m_lol;
    bit       m_ls;

    task automatic go(input int ph);
        m_ph  = ph;
        m_age = 0;
    endtask

    task automatic model_step();
        m_ls  = m_sync[1];
        m_lol = 1'b0;
        if (rst) begin
            go(P_HOLD);
            m_retry = 0;
            m_sync  = 2'b00;
        end else begin
            m_sync = {m_sync[0], bus.mmcm_locked};
            m_age++;
            if (bus.pwrdwn_req) begin
                go(P_OFF);
            end else begin
                case (m_ph)
                    P_HOLD: if (m_age == RH) go(P_WAIT);
                    P_WAIT: begin
                        if (m_ls) go(P_STAB);
                        else if (m_age == TO) begin
                            if (m_retry < MR) begin
                                m_retry++;
                                go(P_HOLD);
                            end else go(P_FLT);
                        end
                    end
                    P_STAB: begin
                        if (!m_ls) go(P_WAIT);
                        else if (m_age == LS) go(P_RUN);
                    end
                    P_RUN: begin
                        if (!m_ls) begin
                            m_lol = 1'b1;
                            if (AR) begin
                                go(P_HOLD);
                                m_retry = 0;
                            end else go(P_FLT);
                        end
                    end
                    P_OFF: begin
                        go(P_HOLD);
                        m_retry = 0;
                    end
                    default: begin
                        if (bus.fault_clr) begin
                            go(P_HOLD);
                            m_retry = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {bus.mmcm_rst, bus.mmcm_pwrdwn, bus.ready,
                bus.fault, bus.lol_pulse, bus.retry_cnt};
    endfunction

    function automatic logic [8:0] model_vec();
        logic r;
        r = (m_ph == P_HOLD) || (m_ph == P_OFF) || (m_ph == P_FLT);
        return {r, m_ph == P_OFF, m_ph == P_RUN,
                m_ph == P_FLT, m_lol, 4'(m_retry)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL model t=%0t: got %b, want %b",
                     $time, dut_vec(), model_vec());
        end
    endtask

    typedef struct {
        bit    rst, lk, pwr, clr;
        int    cyc;
        bit    e_rst, e_pwr, e_rdy, e_flt, e_lol;
        int    e_rty;
        string name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, l, p, c, input int cyc,
                       input bit er, ep, ed, ef, el, input int et,
                       input string nm);
        vec_t v;
        v.rst = r; v.lk = l; v.pwr = p; v.clr = c; v.cyc = cyc;
        v.e_rst = er; v.e_pwr = ep; v.e_rdy = ed;
        v.e_flt = ef; v.e_lol = el; v.e_rty = et; v.name = nm;
        tbl.push_back(v);
    endtask

    bit tr_rst[NTR];
    bit tr_flt[NTR];
    int tr_rty[NTR];

    initial begin
        int       starts[$];
        int       widths[$];
        int       rtys[$];
        int       fidx;
        int       n;
        int       w;
        int       rate;
        logic     bad;
        logic [8:0] exp_v;

        rst = 1'b1;
        bus.mmcm_locked = 1'b0;
        bus.pwrdwn_req  = 1'b0;
        bus.fault_clr   = 1'b0;

        //  rst lk pwr clr cyc  mrst pwd rdy flt lol rty
        add(1, 0, 0, 0, 2,  1, 0, 0, 0, 0, 0, "reset");
        add(0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, "hold3");
        add(0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, "hold_end");
        add(0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0, "wait20");
        add(0, 1, 0, 0, 10, 0, 0, 0, 0, 0, 0, "lat10");
        add(0, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0, "lat11");
        add(0, 1, 0, 0, 5,  0, 0, 1, 0, 0, 0, "run");
        add(1, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, "rst_in_run");
        add(0, 1, 0, 0, 4,  0, 0, 0, 0, 0, 0, "rehold");
        add(0, 1, 1, 1, 1,  1, 1, 0, 0, 0, 0, "pwrdn");
        add(0, 1, 1, 0, 5,  1, 1, 0, 0, 0, 0, "pwrdn_hold");
        add(0, 1, 0, 0, 1,  1, 0, 0, 0, 0, 0, "pwr_rel");
        add(0, 1, 0, 0, 3,  1, 0, 0, 0, 0, 0, "pwr_hold3");
        add(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, "pwr_hold4");
        add(0, 1, 0, 0, 8,  0, 0, 0, 0, 0, 0, "relock8");
        add(0, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0, "relock9");
        add(0, 0, 0, 0, 2,  0, 0, 1, 0, 0, 0, "lol_pre");
        add(0, 0, 0, 0, 1,  1, 0, 0, !AR, 1, 0, "lol");
        add(0, 0, 0, 0, 1,  1, 0, 0, !AR, 0, 0, "lol_once");
        add(0, 0, 0, 0, 2,  1, 0, 0, !AR, 0, 0, "lol_hold");
        add(0, 0, 0, 0, 1,  !AR, 0, 0, !AR, 0, 0, "lol_after");
        add(0, 0, 0, 1, 1,  !AR, 0, 0, 0, 0, 0, "flt_clr");
        add(0, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0, "converge");

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            bus.mmcm_locked = tbl[i].lk;
            bus.pwrdwn_req  = tbl[i].pwr;
            bus.fault_clr   = tbl[i].clr;
            repeat (tbl[i].cyc) tick();
            exp_v = {tbl[i].e_rst, tbl[i].e_pwr, tbl[i].e_rdy,
                     tbl[i].e_flt, tbl[i].e_lol, 4'(tbl[i].e_rty)};
            n_cmp++;
            if (dut_vec() !== exp_v) begin
                n_err++;
                $display("FAIL vec %s: got %b, want %b",
                         tbl[i].name, dut_vec(), exp_v);
            end
        end
        bus.fault_clr = 1'b0;

        // retries exhausted with lock held low
        rst = 1'b1;
        bus.mmcm_locked = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NTR; i++) begin
            tr_rst[i] = bus.mmcm_rst;
            tr_flt[i] = bus.fault;
            tr_rty[i] = int'(bus.retry_cnt);
            tick();
        end
        fidx = -1;
        for (int i = 0; i < NTR; i++) begin
            if (tr_flt[i] && fidx < 0) fidx = i;
            if (tr_rst[i] && !tr_flt[i] && (i == 0 || !tr_rst[i-1])) begin
                w = 0;
                for (int j = i; j < NTR && tr_rst[j] && !tr_flt[j]; j++) w++;
                starts.push_back(i);
                widths.push_back(w);
                rtys.push_back(tr_rty[i]);
            end
        end
        chk("pulse_count", starts.size(), MR + 1);
        for (int k = 0; k < starts.size() && k <= MR; k++) begin
            chk($sformatf("pulse%0d_start", k), starts[k], k * (RH + TO));
            chk($sformatf("pulse%0d_width", k), widths[k], RH);
            chk($sformatf("pulse%0d_retry", k), rtys[k], k);
        end
        chk("fault_at", fidx, (MR + 1) * (RH + TO));
        chk("fault_retry", int'(bus.retry_cnt), MR);
        chk("fault_rst", int'(bus.mmcm_rst), 1);

        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        chk("clr_retry", int'(bus.retry_cnt), 0);
        chk("clr_fault", int'(bus.fault), 0);
        w = 0;
        for (int i = 0; i < 20 && bus.mmcm_rst; i++) begin
            w++;
            tick();
        end
        chk("clr_pulse", w, RH);

        // burn one attempt so the retry count is nonzero
        n = 0;
        while (!bus.mmcm_rst && n < TO + 50) begin
            tick();
            n++;
        end
        chk("timeout_len", n, TO);
        n = 0;
        while (bus.mmcm_rst && n < 10) begin
            tick();
            n++;
        end
        chk("retry_hold", n, RH);

        // lock dropout while the stable count is at 5
        bad = 1'b0;
        bus.mmcm_locked = 1'b1;
        repeat (6) begin
            tick();
            bad = bad | bus.ready | bus.mmcm_rst;
        end
        bus.mmcm_locked = 1'b0;
        repeat (3) begin
            tick();
            bad = bad | bus.ready | bus.mmcm_rst;
        end
        bus.mmcm_locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.ready && n < 40);
        chk("drop_quiet", int'(bad), 0);
        chk("drop_latency", n, LS + 3);
        chk("drop_retry", int'(bus.retry_cnt), 1);

        // random run against the model
        rate = 30;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: rate = 6;
                    1: rate = 40;
                    default: rate = 300;
                endcase
            end
            if ($urandom_range(0, rate - 1) == 0)
                bus.mmcm_locked = ~bus.mmcm_locked;
            if (!bus.pwrdwn_req)
                bus.pwrdwn_req = ($urandom_range(0, 299) == 0);
            else
                bus.pwrdwn_req = ($urandom_range(0, 9) != 0);
            bus.fault_clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
